// File: rtl/elev_pkg.sv
// elev_pkg: call codes, FSM state encoding and code decoding shared by the elevator blocks
package elev_pkg;
  localparam int FLOOR_W = 2;
  localparam logic [2:0] CALL_NONE = 3'b000;
  localparam logic [2:0] CALL_1U = 3'b001;
  localparam logic [2:0] CALL_2U = 3'b010;
  localparam logic [2:0] CALL_3U = 3'b011;
  localparam logic [2:0] CALL_4D = 3'b100;
  localparam logic [2:0] CALL_2D = 3'b110;
  localparam logic [2:0] CALL_3D = 3'b111;
  typedef enum logic [1:0] {IDLE, FETCH, MOVE, DOOR} state_t;
  // Returns {valid, floor}; NONE and the illegal code 101 come back invalid
  function automatic logic [FLOOR_W:0] code_floor(input logic [2:0] code);
    case (code)
      CALL_1U: return {1'b1, 2'd0};
      CALL_2U, CALL_2D: return {1'b1, 2'd1};
      CALL_3U, CALL_3D: return {1'b1, 2'd2};
      CALL_4D: return {1'b1, 2'd3};
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/elev_timer.sv
// elev_timer: loadable down-counter shared by travel and door periods
//  clk, rst_n : clock, synchronous active-low reset
//  load, value: load the counter with value (load wins over en)
//  en         : count down by one, stopping at zero
//  zero       : counter is zero
module elev_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= value;
    else if (en && !zero) cnt <= cnt - W'(1);
  end
endmodule

// File: rtl/elev_car_ctrl.sv
// elev_car_ctrl: pulls hall calls from the request buffer, drives the car floor by floor and holds the door
//  clk, rst_n : clock, synchronous active-low reset
//  estop      : emergency stop freeze, present only with ELEV_ESTOP_EN defined
//  q_empty    : buffer has no pending call
//  req        : call code, valid the cycle after a done pulse
//  done       : one-cycle pop pulse to the buffer
//  floor      : current floor index 0..3
//  dir_up, dir_down, door_open : car motion and door status
//  busy       : controller not idle
module elev_car_ctrl
  import elev_pkg::*;
#(
  parameter int TRAVEL_CYC  = 8,
  parameter int DOOR_CYC    = 4,
  parameter int RESET_FLOOR = 0
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef ELEV_ESTOP_EN
  input  logic       estop,
`endif
  input  logic       q_empty,
  input  logic [2:0] req,
  output logic       done,
  output logic [1:0] floor,
  output logic       dir_up,
  output logic       dir_down,
  output logic       door_open,
  output logic       busy
);
  localparam int TMAX = TRAVEL_CYC > DOOR_CYC ? TRAVEL_CYC : DOOR_CYC;
  localparam int TW = $clog2(TMAX) + 1;
  state_t state;
  logic done_r, run, zero, arrive, fetch_go, to_door, tmr_load, tmr_en;
  logic [1:0] target, next_floor;
  logic [FLOOR_W:0] dec;
  logic [TW-1:0] tmr_val;
`ifdef ELEV_ESTOP_EN
  // Frozen cycles hide a pending done; it reappears on release so the pop still happens once
  assign run = ~estop;
  assign done = done_r & ~estop;
`else
  assign run = 1'b1;
  assign done = done_r;
`endif
  assign busy = state != IDLE;
  // Timer holds period-1 so its zero cycle is the last cycle of each travel/door period
  always_comb begin
    dec = code_floor(req);
    next_floor = dir_up ? floor + 2'd1 : floor - 2'd1;
    arrive = state == MOVE && zero && next_floor == target;
    fetch_go = state == FETCH && dec[FLOOR_W];
    to_door = arrive || (fetch_go && dec[1:0] == floor);
    tmr_load = run && (fetch_go || (state == MOVE && zero));
    tmr_en = run && (state == MOVE || state == DOOR);
    tmr_val = to_door ? TW'(DOOR_CYC - 1) : TW'(TRAVEL_CYC - 1);
  end
  elev_timer #(.W(TW)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (tmr_load),
    .value(tmr_val),
    .en   (tmr_en),
    .zero (zero)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      floor <= FLOOR_W'(RESET_FLOOR);
      target <= '0;
      done_r <= 1'b0;
      dir_up <= 1'b0;
      dir_down <= 1'b0;
      door_open <= 1'b0;
    end else if (run) begin
      case (state)
        IDLE: begin
          done_r <= ~done_r & ~q_empty;
          state <= done_r ? FETCH : IDLE;
        end
        FETCH: begin
          target <= dec[1:0];
          if (!dec[FLOOR_W]) state <= IDLE;
          else if (dec[1:0] == floor) begin
            state <= DOOR;
            door_open <= 1'b1;
          end else begin
            state <= MOVE;
            dir_up <= dec[1:0] > floor;
            dir_down <= dec[1:0] < floor;
          end
        end
        MOVE: if (zero) begin
          floor <= next_floor;
          if (arrive) begin
            state <= DOOR;
            dir_up <= 1'b0;
            dir_down <= 1'b0;
            door_open <= 1'b1;
          end
        end
        DOOR: if (zero) begin
          state <= IDLE;
          door_open <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
